// File: rtl/axilite_gpio_slave.sv
// AXI4-Lite GPIO responder: GPIO_OUT/IN/SET/CLR register file with independent write/read FSMs.
// Optional interrupt block (IRQ_STATUS/IRQ_ENABLE, irq_o) enabled by defining AXILITE_GPIO_SLAVE_IRQ_EN.
module axilite_gpio_slave #(
    parameter int unsigned NUM_GPIO_OUT    = 8,
    parameter int unsigned NUM_GPIO_IN     = 8,
    parameter logic [31:0] OUT_RESET_VALUE = 32'h0
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [31:0]             s_axilite_awaddr,
    input  logic [2:0]              s_axilite_awprot,
    input  logic                    s_axilite_awvalid,
    output logic                    s_axilite_awready,
    input  logic [31:0]             s_axilite_wdata,
    input  logic [3:0]              s_axilite_wstrb,
    input  logic                    s_axilite_wvalid,
    output logic                    s_axilite_wready,
    output logic [1:0]              s_axilite_bresp,
    output logic                    s_axilite_bvalid,
    input  logic                    s_axilite_bready,
    input  logic [31:0]             s_axilite_araddr,
    input  logic [2:0]              s_axilite_arprot,
    input  logic                    s_axilite_arvalid,
    output logic                    s_axilite_arready,
    output logic [31:0]             s_axilite_rdata,
    output logic [1:0]              s_axilite_rresp,
    output logic                    s_axilite_rvalid,
    input  logic                    s_axilite_rready,
    input  logic [NUM_GPIO_IN-1:0]  gpio_in_i,
`ifdef AXILITE_GPIO_SLAVE_IRQ_EN
    output logic                    irq_o,
`endif
    output logic [NUM_GPIO_OUT-1:0] gpio_out_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned IDX_W  = 3;

    localparam logic [IDX_W-1:0] REG_OUT = 3'd0;
    localparam logic [IDX_W-1:0] REG_IN  = 3'd1;
    localparam logic [IDX_W-1:0] REG_SET = 3'd2;
    localparam logic [IDX_W-1:0] REG_CLR = 3'd3;
`ifdef AXILITE_GPIO_SLAVE_IRQ_EN
    localparam logic [IDX_W-1:0] REG_IRQ_STATUS = 3'd4;
    localparam logic [IDX_W-1:0] REG_IRQ_ENABLE = 3'd5;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [IDX_W-1:0]        aw_idx_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic [NUM_GPIO_IN-1:0]  sync1_q, sync2_q;
    logic [NUM_GPIO_OUT-1:0] gpio_out_q;

    logic                    aw_hs_c, w_hs_c, ar_hs_c;
    logic                    wr_do_c, wr_ok_c;
    logic [IDX_W-1:0]        wr_idx_c;
    logic [DATA_W-1:0]       wr_data_c, wmask_c, out_full_c;
    logic [STRB_W-1:0]       wr_strb_c;
    logic [NUM_GPIO_OUT-1:0] gpio_out_next_c;
    logic [DATA_W-1:0]       rd_data_c;
    logic                    rd_err_c;

    wire unused_ok = ^{s_axilite_awprot, s_axilite_arprot,
                       s_axilite_awaddr[31:5], s_axilite_awaddr[1:0],
                       s_axilite_araddr[31:5], s_axilite_araddr[1:0]};

    assign aw_hs_c = s_axilite_awvalid & s_axilite_awready;
    assign w_hs_c  = s_axilite_wvalid  & s_axilite_wready;
    assign ar_hs_c = s_axilite_arvalid & s_axilite_arready;

    // Write FSM next state; selects the live or latched half of each write.
    always_comb begin
        wr_next   = wr_state;
        wr_do_c   = 1'b0;
        wr_idx_c  = aw_idx_q;
        wr_data_c = wdata_q;
        wr_strb_c = wstrb_q;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    wr_do_c   = 1'b1;
                    wr_idx_c  = s_axilite_awaddr[4:2];
                    wr_data_c = s_axilite_wdata;
                    wr_strb_c = s_axilite_wstrb;
                    wr_next   = WR_RESP;
                end else if (aw_hs_c) begin
                    wr_next = WR_WAIT_W;
                end else if (w_hs_c) begin
                    wr_next = WR_WAIT_AW;
                end
            end
            WR_WAIT_W: begin
                if (w_hs_c) begin
                    wr_do_c   = 1'b1;
                    wr_data_c = s_axilite_wdata;
                    wr_strb_c = s_axilite_wstrb;
                    wr_next   = WR_RESP;
                end
            end
            WR_WAIT_AW: begin
                if (aw_hs_c) begin
                    wr_do_c  = 1'b1;
                    wr_idx_c = s_axilite_awaddr[4:2];
                    wr_next  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axilite_bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Register write effects with byte-lane masking.
    always_comb begin
        wmask_c         = '0;
        out_full_c      = DATA_W'(gpio_out_q);
        gpio_out_next_c = gpio_out_q;
        wr_ok_c         = 1'b0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            wmask_c[8*i +: 8] = {8{wr_strb_c[i]}};
        end
        case (wr_idx_c)
            REG_OUT: begin
                wr_ok_c         = 1'b1;
                gpio_out_next_c = NUM_GPIO_OUT'((out_full_c & ~wmask_c) | (wr_data_c & wmask_c));
            end
            REG_SET: begin
                wr_ok_c         = 1'b1;
                gpio_out_next_c = NUM_GPIO_OUT'(out_full_c | (wr_data_c & wmask_c));
            end
            REG_CLR: begin
                wr_ok_c         = 1'b1;
                gpio_out_next_c = NUM_GPIO_OUT'(out_full_c & ~(wr_data_c & wmask_c));
            end
`ifdef AXILITE_GPIO_SLAVE_IRQ_EN
            REG_IRQ_STATUS, REG_IRQ_ENABLE: wr_ok_c = 1'b1;
`endif
            default: wr_ok_c = 1'b0;
        endcase
    end

    // Write channel state, latches, responses and GPIO_OUT.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_state          <= WR_IDLE;
            aw_idx_q          <= '0;
            wdata_q           <= '0;
            wstrb_q           <= '0;
            s_axilite_awready <= 1'b0;
            s_axilite_wready  <= 1'b0;
            s_axilite_bvalid  <= 1'b0;
            s_axilite_bresp   <= RESP_OKAY;
            gpio_out_q        <= NUM_GPIO_OUT'(OUT_RESET_VALUE);
        end else begin
            wr_state          <= wr_next;
            s_axilite_awready <= (wr_next == WR_IDLE) || (wr_next == WR_WAIT_AW);
            s_axilite_wready  <= (wr_next == WR_IDLE) || (wr_next == WR_WAIT_W);
            s_axilite_bvalid  <= (wr_next == WR_RESP);
            if (aw_hs_c) aw_idx_q <= s_axilite_awaddr[4:2];
            if (w_hs_c) begin
                wdata_q <= s_axilite_wdata;
                wstrb_q <= s_axilite_wstrb;
            end
            if (wr_do_c) begin
                s_axilite_bresp <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok_c) gpio_out_q <= gpio_out_next_c;
            end
        end
    end

    // Input synchroniser.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef AXILITE_GPIO_SLAVE_IRQ_EN
    logic [NUM_GPIO_IN-1:0] sync3_q, irq_status_q, irq_enable_q, edge_c, wr_bits_c;

    assign edge_c    = sync2_q & ~sync3_q;
    assign wr_bits_c = NUM_GPIO_IN'(wr_data_c & wmask_c);

    // Edge capture wins over a same-cycle W1C of the same bit.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync3_q      <= '0;
            irq_status_q <= '0;
            irq_enable_q <= '0;
            irq_o        <= 1'b0;
        end else begin
            sync3_q <= sync2_q;
            irq_o   <= |(irq_status_q & irq_enable_q);
            if (wr_do_c && (wr_idx_c == REG_IRQ_STATUS)) begin
                irq_status_q <= (irq_status_q & ~wr_bits_c) | edge_c;
            end else begin
                irq_status_q <= irq_status_q | edge_c;
            end
            if (wr_do_c && (wr_idx_c == REG_IRQ_ENABLE)) begin
                irq_enable_q <= (irq_enable_q & ~NUM_GPIO_IN'(wmask_c)) | wr_bits_c;
            end
        end
    end
`endif

    // Read decode.
    always_comb begin
        rd_data_c = '0;
        rd_err_c  = 1'b0;
        case (s_axilite_araddr[4:2])
            REG_OUT:          rd_data_c = DATA_W'(gpio_out_q);
            REG_IN:           rd_data_c = DATA_W'(sync2_q);
            REG_SET, REG_CLR: rd_data_c = '0;
`ifdef AXILITE_GPIO_SLAVE_IRQ_EN
            REG_IRQ_STATUS:   rd_data_c = DATA_W'(irq_status_q);
            REG_IRQ_ENABLE:   rd_data_c = DATA_W'(irq_enable_q);
`endif
            default:          rd_err_c  = 1'b1;
        endcase
    end

    // Read FSM next state.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs_c) rd_next = RD_RESP;
            RD_RESP: if (s_axilite_rready) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_state          <= RD_IDLE;
            s_axilite_arready <= 1'b0;
            s_axilite_rvalid  <= 1'b0;
            s_axilite_rdata   <= '0;
            s_axilite_rresp   <= RESP_OKAY;
        end else begin
            rd_state          <= rd_next;
            s_axilite_arready <= (rd_next == RD_IDLE);
            s_axilite_rvalid  <= (rd_next == RD_RESP);
            if (ar_hs_c) begin
                s_axilite_rdata <= rd_data_c;
                s_axilite_rresp <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign gpio_out_o = gpio_out_q;

endmodule
